// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Write side of the ELVM program store. The block takes a byte stream over a
// valid/ready handshake and parses it as a load frame:
//
//   LEN (N, 0 means 256) | N words of 4 bytes, LSB first | CSUM
//
// Each complete word is written to the program RAM at incrementing addresses.
// CSUM is the XOR of all payload bytes. A mismatching CSUM, or any nonzero pad
// bit in the top byte of a word, raises err. err is meaningful once done is
// set.
//
// Ports
//   clk, rst      : clock and asynchronous active-high reset
//   start         : begin a session (only sampled in IDLE or DONE)
//   in_data       : stream byte
//   in_valid      : in_data is valid
//   in_ready      : loader accepts a byte this cycle
//   we            : program RAM write strobe, one cycle per word
//   waddr         : program RAM write address
//   wdata         : program RAM write data
//   busy          : session in progress (LEN, DATA or CSUM)
//   done          : session finished; held until next start or reset
//   err           : checksum mismatch or nonzero pad bits
//   word_count    : words written in the current or last session
//
// Every output is driven straight from a flop, so there is no combinational
// path from any input to any output.
// ---------------------------------------------------------------------------
module prog_loader #(
  parameter int WORD_W = 26,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [WORD_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  // Bits of the fourth byte that belong to the word. The rest are pad bits.
  localparam int TOP_BITS = WORD_W - 24;
  localparam int ASM_W    = WORD_W - TOP_BITS;
  localparam int CNT_W    = ADDR_W + 1;

  // Word count of a full-depth load. LEN=0 selects it.
  localparam logic [CNT_W-1:0] FULL_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEN  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_CSUM = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [ASM_W-1:0]  asm_q, asm_d;
  logic [7:0]        csum_q, csum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              xfer;
  logic [7:0]        pad_bits;
  logic [CNT_W-1:0]  count_inc;

  // in_ready is registered, so the handshake uses the flopped copy.
  assign xfer     = in_valid && in_ready_q;
  assign pad_bits = in_data >> TOP_BITS;

  // word_count never exceeds a full-depth load.
  assign count_inc = (word_count_q == FULL_DEPTH) ? word_count_q
                                                  : word_count_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    byte_idx_d   = byte_idx_q;
    asm_d        = asm_q;
    csum_d       = csum_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    word_count_d = word_count_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_LEN;
          word_count_d = '0;
          err_d        = 1'b0;
          csum_d       = 8'd0;
          byte_idx_d   = 2'd0;
        end
      end

      ST_LEN: begin
        if (xfer) begin
          len_d   = (in_data == 8'd0) ? FULL_DEPTH : CNT_W'(in_data);
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (xfer) begin
          csum_d     = csum_q ^ in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // The fourth byte completes the word. The write goes out next
            // cycle at the pre-increment count, while the next word's first
            // byte can already be accepted.
            we_d         = 1'b1;
            waddr_d      = word_count_q[ADDR_W-1:0];
            wdata_d      = {in_data[TOP_BITS-1:0], asm_q};
            word_count_d = count_inc;
            if (pad_bits != 8'd0) begin
              err_d = 1'b1;
            end
            if (count_inc == len_q) begin
              state_d = ST_CSUM;
            end
          end else begin
            // Shift in from the top so byte0 ends up in the low bits after
            // three bytes.
            asm_d = {in_data, asm_q[ASM_W-1:8]};
          end
        end
      end

      ST_CSUM: begin
        if (xfer) begin
          if (in_data != csum_q) begin
            err_d = 1'b1;
          end
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are decoded from the next state so that they are flops
    // aligned with the state register.
    in_ready_d = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CSUM);
    busy_d     = in_ready_d;
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      byte_idx_q   <= 2'd0;
      asm_q        <= '0;
      csum_q       <= 8'd0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      word_count_q <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      byte_idx_q   <= byte_idx_d;
      asm_q        <= asm_d;
      csum_q       <= csum_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      word_count_q <= word_count_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign we         = we_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = word_count_q;

endmodule

// File: doc/prog_loader.md
# prog_loader

Instruction-memory loader for the ELVM CPU: the write side of the 256 × 26-bit program store that the CPU fetch path reads combinationally. It accepts a byte stream (for example from a UART receiver) over a valid/ready handshake. It assembles little-endian 26-bit instruction words and issues one write per word into the program RAM at incrementing addresses. A trailing XOR checksum is verified, so a program can be replaced at run time instead of only at elaboration.

## Interface

Parameters:

- WORD_W, 26, instruction word width
- ADDR_W, 8, program address width (256 words)

Ports:

- clk, input, 1, system clock; all state updates on rising edge
- rst, input, 1, reset; asynchronous, active-high
- start, input, 1, begin a load session; sampled only in IDLE or DONE
- in_data, input, 8, stream byte
- in_valid, input, 1, in_data valid
- in_ready, output, 1, loader accepts a byte this cycle; a transfer happens when in_valid && in_ready
- we, output, 1, program RAM write strobe, one cycle per word
- waddr, output, ADDR_W, program RAM write address
- wdata, output, WORD_W, program RAM write data
- busy, output, 1, session in progress (LEN, DATA or CSUM)
- done, output, 1, session finished; held until the next start or reset
- err, output, 1, checksum mismatch or nonzero pad bits; valid while done=1
- word_count, output, ADDR_W+1, number of words written in the current or last session

## Operation

- Frame layout: LEN byte N, then N×4 payload bytes, then CSUM byte.
  - N=0 means 256 words.
  - Each word is sent as byte0..byte3, least significant byte first.
  - wdata = {byte3[1:0], byte2, byte1, byte0}.
  - byte3[7:2] must be zero. Any nonzero pad bit sets the err flag; the word is still written, with the pad bits dropped.
  - CSUM must equal the XOR of all payload bytes; LEN is excluded from the checksum.
- States:
  - IDLE: in_ready=0. start moves to LEN; clears word_count, err, the checksum accumulator and the byte index.
  - LEN: in_ready=1. On transfer, latch N (0 is treated as 256) and move to DATA.
  - DATA: in_ready=1. Each transfer XORs the byte into the accumulator and shifts it into the assembly register; the 2-bit byte index increments.
    - On the transfer with index=3, the next cycle has we=1 and waddr = word_count[ADDR_W-1:0]. In that same cycle word_count increments.
    - When word_count reaches N, move to CSUM.
  - CSUM: in_ready=1. On transfer, err |= (byte != accumulator); move to DONE.
  - DONE: in_ready=0, done=1. start returns to LEN with the same clears as IDLE, and drops done.
- start while busy is ignored.
- A new byte may be accepted in the same cycle that we is high; no stall is ever inserted.
- Reset mid-session aborts the session; RAM contents already written are not restored.
- waddr wraps naturally, with 256 words as the maximum; word_count saturates at its 9-bit value of 256.

## Timing

- Reset values: state IDLE, in_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, err=0, word_count=0.
- start→busy: 1 cycle. in_ready rises the cycle after start is sampled.
- Accepting the 4th byte of a word at edge k gives we=1 during cycle k+1.
  - waddr and wdata are registered and stable for that whole cycle.
  - we is exactly 1 cycle wide.
- Back-to-back words at full rate give a write every 4 cycles.
- Accepting the CSUM byte at edge k gives done=1, busy=0 and final err during cycle k+1.
- in_valid gaps stall state without side effects; in_data is ignored when in_valid=0.
- All outputs are registered, so there is no combinational path from inputs to outputs.

## Test plan

- Normal load: start, then bytes 02 | 43 00 00 01 | 44 00 FF 02 | FB.
  - Required: writes addr0=0x1000043 and addr1=0x2FF0044, each as a single-cycle we.
  - Final state: done=1, err=0, word_count=2, busy=0.
- Bad checksum: same frame with CSUM=00.
  - Required: both writes occur; done=1, err=1.
- Pad violation: 01 | 78 56 34 05 | CSUM=0x1F.
  - Required: write addr0 = 0x1345678; done=1, err=1.
- Full-depth load: LEN=00 followed by 1024 payload bytes with the correct CSUM.
  - Required: 256 writes with addresses 0x00..0xFF in order; word_count=256; err=0.
- Handshake and abort:
  - Random in_valid gaps yield the same writes as the normal-load case.
  - start pulsed during DATA is ignored.
  - rst asserted after 5 payload bytes clears all outputs to their reset values immediately.
  - A new start then writes beginning at addr0.
- Restart from DONE: after the bad-checksum case, a new start clears done/err/word_count in 1 cycle, and the normal-load frame ends with err=0.
